// File: rtl/parking_gate_ctrl.sv
// Parking entry barrier controller.
// Sequences the gate on request and tracks park occupancy.
module parking_gate_ctrl #(
  parameter int CAP        = 15,
  parameter int CW         = 4,
  parameter int OPEN_TICKS = 8,
  parameter int TW         = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_in,
  input  logic          ent,
  input  logic          ext,
  output logic          gate_open,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          deny,
  output logic          timeout,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CAPV  = CW'(CAP);
  localparam logic [TW-1:0] TLOAD = TW'(OPEN_TICKS - 1);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic [CW-1:0] count_nx;
  logic          deny_nx;
  logic          timeout_nx;
  logic          err_nx;
  logic          at_cap;
  logic          at_zero;
  logic          inc;
  logic          dec;

  assign at_cap  = (count == CAPV);
  assign at_zero = (count == '0);
  assign inc     = ent & ~ext;
  assign dec     = ~ent & ext;

  assign gate_open = (state == OPEN);
  assign full      = at_cap;
  assign empty     = at_zero;

  // Gate sequencing: open on request unless full, close on entry or expiry.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    deny_nx    = 1'b0;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_in) begin
          if (at_cap) begin
            deny_nx = 1'b1;
          end else begin
            state_nx = OPEN;
            timer_nx = TLOAD;
          end
        end
      end
      OPEN: begin
        if (ent) begin
          state_nx = CLOSE;
        end else if (timer == '0) begin
          state_nx   = CLOSE;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      CLOSE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Occupancy: saturating count, anomaly on bound hit or entry while shut.
  always_comb begin
    count_nx = count;
    err_nx   = 1'b0;
    unique case (1'b1)
      inc: begin
        if (at_cap) err_nx = 1'b1;
        else        count_nx = count + CW'(1);
      end
      dec: begin
        if (at_zero) err_nx = 1'b1;
        else         count_nx = count - CW'(1);
      end
      default: begin
        count_nx = count;
      end
    endcase
    if (ent && state != OPEN) err_nx = 1'b1;
  end

  // State, timer, occupancy and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      count   <= '0;
      deny    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      count   <= count_nx;
      deny    <= deny_nx;
      timeout <= timeout_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl.
// Default instance plus a CAP=3 instance on shared inputs.
module tb_parking_gate_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req_in;
  logic       ent;
  logic       ext;

  logic       d_gate, d_full, d_empty, d_deny, d_to, d_err;
  logic [3:0] d_count;
  logic       c_gate, c_full, c_empty, c_deny, c_to, c_err;
  logic [3:0] c_count;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_in    (req_in),
    .ent       (ent),
    .ext       (ext),
    .gate_open (d_gate),
    .count     (d_count),
    .full      (d_full),
    .empty     (d_empty),
    .deny      (d_deny),
    .timeout   (d_to),
    .err       (d_err)
  );

  parking_gate_ctrl #(.CAP(3)) u_cap3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_in    (req_in),
    .ent       (ent),
    .ext       (ext),
    .gate_open (c_gate),
    .count     (c_count),
    .full      (c_full),
    .empty     (c_empty),
    .deny      (c_deny),
    .timeout   (c_to),
    .err       (c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_in  = 1'b0;
    ent     = 1'b0;
    ext     = 1'b0;
    step();
    step();
    chk("rst_gate", d_gate, 0);
    chk("rst_count", d_count, 0);
    chk("rst_empty", d_empty, 1);
    chk("rst_full", d_full, 0);
    chk("rst_deny", d_deny, 0);
    chk("rst_to", d_to, 0);
    chk("rst_err", d_err, 0);
    reset_n = 1'b1;
    step();

    // timeout path
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    chk("t1_open", d_gate, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t1_hold", d_gate, 1);
      chk("t1_noto", d_to, 0);
    end
    step();
    chk("t1_shut", d_gate, 0);
    chk("t1_to", d_to, 1);
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    chk("t1_close_ign", d_gate, 0);
    chk("t1_to_pulse", d_to, 0);
    chk("t1_count", d_count, 0);

    // normal entry
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    chk("t2_open", d_gate, 1);
    step();
    step();
    ent = 1'b1;
    step();
    ent = 1'b0;
    chk("t2_gate", d_gate, 0);
    chk("t2_count", d_count, 1);
    chk("t2_empty", d_empty, 0);
    chk("t2_err", d_err, 0);
    chk("t2_to", d_to, 0);
    step();

    // fill CAP=3 instance
    for (int k = 0; k < 2; k++) begin
      req_in = 1'b1;
      step();
      req_in = 1'b0;
      ent = 1'b1;
      step();
      ent = 1'b0;
      step();
    end
    chk("t3_count", c_count, 3);
    chk("t3_full", c_full, 1);
    chk("t3_dcount", d_count, 3);
    req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_deny", c_deny, 1);
      chk("t3_gate", c_gate, 0);
    end
    req_in = 1'b0;
    step();
    chk("t3_deny_end", c_deny, 0);
    ent = 1'b1;
    step();
    ent = 1'b0;
    chk("t3_icount", c_count, 3);
    chk("t3_ierr", c_err, 1);
    chk("t3_dcount4", d_count, 4);
    step();
    chk("t3_ierr_end", c_err, 0);
    step();

    // async reset with gate open
    ext = 1'b1;
    step();
    step();
    ext = 1'b0;
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    step();
    chk("t6_pre_gate", d_gate, 1);
    chk("t6_pre_count", d_count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_gate", d_gate, 0);
    chk("t6_count", d_count, 0);
    chk("t6_empty", d_empty, 1);
    #1;
    reset_n = 1'b1;
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    chk("t6_reopen", d_gate, 1);
    ent = 1'b1;
    step();
    ent = 1'b0;
    chk("t6_count1", d_count, 1);
    ext = 1'b1;
    step();
    ext = 1'b0;
    chk("t6_count0", d_count, 0);
    chk("t6_err", d_err, 0);
    step();

    // underflow, then net-zero pair
    ext = 1'b1;
    step();
    ext = 1'b0;
    chk("t4_count", d_count, 0);
    chk("t4_err", d_err, 1);
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    ent = 1'b1;
    ext = 1'b1;
    step();
    ent = 1'b0;
    ext = 1'b0;
    chk("t4_both_count", d_count, 0);
    chk("t4_both_err", d_err, 0);
    step();

    // build to 5, then intrusion
    for (int k = 0; k < 5; k++) begin
      req_in = 1'b1;
      step();
      req_in = 1'b0;
      ent = 1'b1;
      step();
      ent = 1'b0;
      step();
    end
    chk("t5_count5", d_count, 5);
    ent = 1'b1;
    step();
    ent = 1'b0;
    chk("t5_icount", d_count, 6);
    chk("t5_ierr", d_err, 1);
    ext = 1'b1;
    step();
    ext = 1'b0;
    chk("t5_xcount", d_count, 5);
    chk("t5_xerr", d_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
